mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4: consecutive contended cycles port B may lose before it is forced to win.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_req, a_we  input  1 each  port A (CPU) access request, write enable.
REQ-005 a_addr, a_wdata  input  16 each  port A address, write data.
REQ-006 a_gnt  output  1  port A access accepted this cycle (combinational).
REQ-007 a_rvalid  output  1  port A read data valid on rdata (registered).
REQ-008 b_req, b_we, b_lock  input  1 each  port B (loader/DMA) request, write enable, burst lock.
REQ-009 b_addr, b_wdata  input  16 each  port B address, write data.
REQ-010 b_gnt  output  1  port B access accepted this cycle (combinational).
REQ-011 b_rvalid  output  1  port B read data valid on rdata (registered).
REQ-012 rdata  output  16  read data, driven directly from mem_dout.
REQ-013 mem_addr, mem_din  output  16 each  to RAM address, write data.
REQ-014 mem_we  output  1  to RAM write enable.
REQ-015 mem_dout  input  16  from RAM; synchronous read, valid one cycle after address is presented.

Function
REQ-016 At most one access SHALL be granted per cycle; a_gnt and b_gnt SHALL never both be 1.
REQ-017 An access SHALL complete on the rising edge ending the cycle in which its gnt is 1; requester holds req/we/addr/wdata stable until gnt.
REQ-018 mem_addr/mem_din SHALL equal the granted port's addr/wdata; with no grant they SHALL hold port A's values; mem_we SHALL equal granted port's we, else 0.
REQ-019 Arbitration: only one req -> that port wins; both -> A wins, except B wins when lock_b=1 or starve_cnt==MAX_WAIT.
REQ-020 starve_cnt (width clog2(MAX_WAIT+1)): increments when b_req=1 and b_gnt=0; clears when b_gnt=1 or b_req=0; saturates at MAX_WAIT.
REQ-021 lock_b register: set when b_gnt=1 and b_lock=1; cleared when b_gnt=1 and b_lock=0, or when b_req=0.
REQ-022 While lock_b=1 and b_req=0 in the same cycle, lock is ignored for arbitration (A may win) and cleared at the edge.
REQ-023 a_rvalid SHALL be 1 in the cycle after a_gnt=1 with a_we=0, else 0; b_rvalid likewise for port B.
REQ-024 Writes SHALL produce no rvalid.
REQ-025 Back-to-back grants SHALL be allowed every cycle; throughput one access per cycle.
REQ-026 Write then read of same address on consecutive cycles SHALL return the newly written data.
REQ-027 Read latency: gnt cycle N -> rvalid and rdata valid cycle N+1.

Reset
REQ-028 While reset=1: a_gnt=0, b_gnt=0, mem_we=0 regardless of requests.
REQ-029 On edge with reset=1: a_rvalid=0, b_rvalid=0, starve_cnt=0, lock_b=0; pending read returns are discarded.
REQ-030 First cycle after reset deasserts SHALL arbitrate normally using reset state.

Verification
REQ-031 A-only read addr 0x0080 (RAM holds 0x1234) -> a_gnt=1 cycle N, a_rvalid=1 and rdata=0x1234 cycle N+1, b_rvalid=0.
REQ-032 B write 0x00AB<-0x01FF, next cycle B read 0x00AB -> b_gnt both cycles, b_rvalid=1 with rdata=0x01FF in third cycle.
REQ-033 A and B request continuously, MAX_WAIT=4, b_lock=0 -> grant pattern A,A,A,A,B repeating; starve_cnt 0..4 then clears.
REQ-034 B granted with b_lock=1 for 3 accesses, A requesting throughout -> B,B,B granted; A granted first cycle after B access with b_lock=0.
REQ-035 B read granted, reset asserted next cycle -> b_rvalid=0, gnts=0, mem_we=0 during reset; starve_cnt=0, lock_b=0 after.
REQ-036 No requests for 10 cycles -> gnts=0, mem_we=0, rvalids=0, starve_cnt remains 0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port single-RAM arbiter. Port A has priority; port B gets
//               a bounded-wait guarantee and can hold the RAM for a burst.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_lock,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [15:0] rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_we,
    input  logic [15:0] mem_dout
);

    localparam int                 c_CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_WAIT);

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               r_lock_b;
    logic               r_a_rvalid;
    logic               r_b_rvalid;
    logic               w_lock_eff;
    logic               w_b_win;
    logic               w_a_win;

    // A stale lock (B no longer requesting) must not block port A.
    always_comb begin
        w_lock_eff = r_lock_b & b_req;
        w_b_win    = b_req & (~a_req | w_lock_eff | (r_starve_cnt == c_MAX_CNT));
        w_a_win    = a_req & ~w_b_win;
    end

    assign a_gnt    = w_a_win & ~reset;
    assign b_gnt    = w_b_win & ~reset;

    assign mem_addr = b_gnt ? b_addr  : a_addr;
    assign mem_din  = b_gnt ? b_wdata : a_wdata;
    assign mem_we   = (a_gnt & a_we) | (b_gnt & b_we);

    assign rdata    = mem_dout;
    // Gating with reset discards a read return that lands in a reset cycle.
    assign a_rvalid = r_a_rvalid & ~reset;
    assign b_rvalid = r_b_rvalid & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
            r_lock_b     <= 1'b0;
            r_a_rvalid   <= 1'b0;
            r_b_rvalid   <= 1'b0;
        end else begin
            r_a_rvalid <= a_gnt & ~a_we;
            r_b_rvalid <= b_gnt & ~b_we;

            if (b_req & ~b_gnt) begin
                if (r_starve_cnt != c_MAX_CNT) begin
                    r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end

            if (!b_req) begin
                r_lock_b <= 1'b0;
            end else if (b_gnt) begin
                r_lock_b <= b_lock;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [15:0] a_addr, a_wdata;
    logic        b_req, b_we, b_lock, b_gnt, b_rvalid;
    logic [15:0] b_addr, b_wdata;
    logic [15:0] rdata, mem_addr, mem_din, mem_dout;
    logic        mem_we;

    logic [15:0] r_ram [0:65535];

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.MAX_WAIT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_lock   (b_lock),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: one-cycle read latency, write visible on the next read.
    always @(posedge clk) begin
        if (mem_we) r_ram[mem_addr] <= mem_din;
        mem_dout <= r_ram[mem_addr];
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        a_req = 1'b0; a_we = 1'b0; a_addr = 16'h0055; a_wdata = 16'h0000;
        b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = 16'h0000; b_wdata = 16'h0000;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) r_ram[i] = 16'h0000;
        r_ram[16'h0080] = 16'h1234;

        // Reset with both ports trying to write
        reset = 1'b1;
        set_idle();
        a_req = 1'b1; a_we = 1'b1; b_req = 1'b1; b_we = 1'b1;
        @(negedge clk);
        chk_val("rst_a_gnt", a_gnt, 0);
        chk_val("rst_b_gnt", b_gnt, 0);
        chk_val("rst_mem_we", mem_we, 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk_val("rst_a_rvalid", a_rvalid, 0);
        chk_val("rst_b_rvalid", b_rvalid, 0);
        chk_val("rst_starve", dut.r_starve_cnt, 0);
        chk_val("rst_lock", dut.r_lock_b, 0);
        next_cycle();
        reset = 1'b0;
        set_idle();
        next_cycle();

        // A-only read of 0x0080
        a_req = 1'b1; a_addr = 16'h0080;
        @(negedge clk);
        chk_val("a_rd_gnt", a_gnt, 1);
        chk_val("a_rd_bgnt", b_gnt, 0);
        chk_val("a_rd_addr", mem_addr, 16'h0080);
        chk_val("a_rd_we", mem_we, 0);
        next_cycle();
        set_idle();
        @(negedge clk);
        chk_val("a_rd_rvalid", a_rvalid, 1);
        chk_val("a_rd_rdata", rdata, 16'h1234);
        chk_val("a_rd_b_rvalid", b_rvalid, 0);
        chk_val("a_rd_gnt_off", a_gnt, 0);
        next_cycle();

        // B write then read-back of the same address
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h00AB; b_wdata = 16'h01FF;
        @(negedge clk);
        chk_val("b_wr_gnt", b_gnt, 1);
        chk_val("b_wr_we", mem_we, 1);
        chk_val("b_wr_addr", mem_addr, 16'h00AB);
        chk_val("b_wr_din", mem_din, 16'h01FF);
        next_cycle();
        b_we = 1'b0; b_wdata = 16'h0000;
        @(negedge clk);
        chk_val("b_rd_gnt", b_gnt, 1);
        chk_val("b_rd_we", mem_we, 0);
        chk_val("b_wr_no_rvalid", b_rvalid, 0);
        next_cycle();
        set_idle();
        @(negedge clk);
        chk_val("b_rd_rvalid", b_rvalid, 1);
        chk_val("b_rd_rdata", rdata, 16'h01FF);
        chk_val("b_rd_a_rvalid", a_rvalid, 0);
        next_cycle();

        // Continuous contention: A,A,A,A,B repeating
        a_req = 1'b1; a_addr = 16'h0080;
        b_req = 1'b1; b_addr = 16'h00AB;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_val($sformatf("cont_a_gnt[%0d]", i), a_gnt, (i % 5) != 4);
            chk_val($sformatf("cont_b_gnt[%0d]", i), b_gnt, (i % 5) == 4);
            chk_val($sformatf("cont_starve[%0d]", i), dut.r_starve_cnt, i % 5);
            if (i > 0) begin
                chk_val($sformatf("cont_a_rvalid[%0d]", i), a_rvalid, ((i - 1) % 5) != 4);
                chk_val($sformatf("cont_b_rvalid[%0d]", i), b_rvalid, ((i - 1) % 5) == 4);
            end
            next_cycle();
        end
        set_idle();
        next_cycle();

        // Locked burst: B wins by starvation, then holds for two more accesses
        a_req = 1'b1; a_addr = 16'h0080;
        b_req = 1'b1; b_we = 1'b1; b_lock = 1'b1; b_addr = 16'h0010; b_wdata = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) b_lock = 1'b0;
            @(negedge clk);
            chk_val($sformatf("lock_b_gnt[%0d]", i), b_gnt, (i >= 4) && (i <= 6));
            chk_val($sformatf("lock_a_gnt[%0d]", i), a_gnt, (i < 4) || (i == 7));
            chk_val($sformatf("lock_reg[%0d]", i), dut.r_lock_b, (i == 5) || (i == 6));
            next_cycle();
        end
        set_idle();
        next_cycle();

        // Stale lock with b_req low is ignored and cleared
        b_req = 1'b1; b_lock = 1'b1; b_addr = 16'h0020;
        @(negedge clk);
        chk_val("stale_b_gnt", b_gnt, 1);
        next_cycle();
        b_req = 1'b0; b_lock = 1'b0;
        a_req = 1'b1; a_addr = 16'h0080;
        @(negedge clk);
        chk_val("stale_lock_set", dut.r_lock_b, 1);
        chk_val("stale_a_gnt", a_gnt, 1);
        next_cycle();
        @(negedge clk);
        chk_val("stale_lock_clr", dut.r_lock_b, 0);
        next_cycle();
        set_idle();

        // B read granted (with lock), reset in the following cycle
        b_req = 1'b1; b_lock = 1'b1; b_addr = 16'h00AB;
        @(negedge clk);
        chk_val("prerst_b_gnt", b_gnt, 1);
        next_cycle();
        reset = 1'b1;
        a_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
        @(negedge clk);
        chk_val("inrst_b_rvalid", b_rvalid, 0);
        chk_val("inrst_a_gnt", a_gnt, 0);
        chk_val("inrst_b_gnt", b_gnt, 0);
        chk_val("inrst_mem_we", mem_we, 0);
        next_cycle();
        reset = 1'b0;
        set_idle();
        @(negedge clk);
        chk_val("postrst_starve", dut.r_starve_cnt, 0);
        chk_val("postrst_lock", dut.r_lock_b, 0);
        chk_val("postrst_b_rvalid", b_rvalid, 0);
        next_cycle();

        // First contended cycle after reset arbitrates from reset state
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        a_req = 1'b1; a_addr = 16'h0080; b_req = 1'b1; b_lock = 1'b1; b_addr = 16'h00AB;
        @(negedge clk);
        chk_val("first_a_gnt", a_gnt, 1);
        chk_val("first_b_gnt", b_gnt, 0);
        next_cycle();
        set_idle();
        next_cycle();

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_val($sformatf("idle_gnt[%0d]", i), {a_gnt, b_gnt}, 0);
            chk_val($sformatf("idle_we[%0d]", i), mem_we, 0);
            chk_val($sformatf("idle_rvalid[%0d]", i), {a_rvalid, b_rvalid}, 0);
            chk_val($sformatf("idle_starve[%0d]", i), dut.r_starve_cnt, 0);
            chk_val($sformatf("idle_addr[%0d]", i), mem_addr, 16'h0055);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
